// File: rtl/regs_wb_arbiter_if.sv
// Bundle of every signal between the write-back arbiter and its neighbours:
// the ALU (A) and load/multicycle (B) requesters, the issue scoreboard,
// the decode busy lookups and the register file write port.
interface regs_wb_arbiter_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            i_a_valid;
   logic [AW-1:0]   i_a_addr;
   logic [XLEN-1:0] i_a_dat;
   logic            o_a_ready;

   logic            i_b_valid;
   logic [AW-1:0]   i_b_addr;
   logic [XLEN-1:0] i_b_dat;
   logic            o_b_ready;

   logic            i_sb_set;
   logic [AW-1:0]   i_sb_rd;

   logic [AW-1:0]   i_rs1;
   logic [AW-1:0]   i_rs2;
   logic            o_busy_rs1;
   logic            o_busy_rs2;

   logic            o_we;
   logic [AW-1:0]   o_addr_wr;
   logic [XLEN-1:0] o_dat_wr;

   // Arbiter side of the bundle.
   modport slave (
      input  i_a_valid, i_a_addr, i_a_dat,
      input  i_b_valid, i_b_addr, i_b_dat,
      input  i_sb_set, i_sb_rd, i_rs1, i_rs2,
      output o_a_ready, o_b_ready, o_busy_rs1, o_busy_rs2,
      output o_we, o_addr_wr, o_dat_wr
   );

   // Requester / decode / register-file side of the bundle.
   modport master (
      output i_a_valid, i_a_addr, i_a_dat,
      output i_b_valid, i_b_addr, i_b_dat,
      output i_sb_set, i_sb_rd, i_rs1, i_rs2,
      input  o_a_ready, o_b_ready, o_busy_rs1, o_busy_rs2,
      input  o_we, o_addr_wr, o_dat_wr
   );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Round-robin between the ALU path (A) and the load/multicycle path (B),
// one registered output stage, and a pending-write scoreboard for B-path
// destinations so decode can stall on read-after-write hazards.
module regs_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input logic i_clk,
   input logic i_rst_n,
   regs_wb_arbiter_if.slave bus
);

   localparam int NREG = 1 << AW;

   logic            last_b;
   logic            grant_a;
   logic            grant_b;
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_next;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] dat_q;

   // Round-robin grant: a lone requester always wins; on contention the
   // path that did not win last time gets the port.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (bus.i_a_valid && bus.i_b_valid) begin
         grant_b = ~last_b;
         grant_a = last_b;
      end else if (bus.i_a_valid) begin
         grant_a = 1'b1;
      end else if (bus.i_b_valid) begin
         grant_b = 1'b1;
      end
   end

   // Remember the most recent winner; idle cycles leave it untouched.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_b <= 1'b1;
      end else if (grant_a || grant_b) begin
         last_b <= grant_b;
      end
   end

   // Output stage: capture the accepted write; x0 writes are swallowed by
   // keeping the enable low while still loading address and data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         dat_q  <= '0;
      end else if (grant_a) begin
         we_q   <= (bus.i_a_addr != '0);
         addr_q <= bus.i_a_addr;
         dat_q  <= bus.i_a_dat;
      end else if (grant_b) begin
         we_q   <= (bus.i_b_addr != '0);
         addr_q <= bus.i_b_addr;
         dat_q  <= bus.i_b_dat;
      end else begin
         we_q   <= 1'b0;
      end
   end

   // Scoreboard update: a completing B write clears its bit first, then a
   // new issue sets it, so a same-cycle issue to the same register wins.
   always_comb begin
      pend_next = pend;
      if (grant_b) begin
         pend_next[bus.i_b_addr] = 1'b0;
      end
      if (bus.i_sb_set && (bus.i_sb_rd != '0)) begin
         pend_next[bus.i_sb_rd] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend <= '0;
      end else begin
         pend <= pend_next;
      end
   end

   // Busy covers both pending B results and a write still sitting in the
   // output stage that the register file has not absorbed yet.
   always_comb begin
      bus.o_busy_rs1 = 1'b0;
      bus.o_busy_rs2 = 1'b0;
      if (bus.i_rs1 != '0) begin
         bus.o_busy_rs1 = pend[bus.i_rs1] | (we_q && (addr_q == bus.i_rs1));
      end
      if (bus.i_rs2 != '0) begin
         bus.o_busy_rs2 = pend[bus.i_rs2] | (we_q && (addr_q == bus.i_rs2));
      end
   end

   assign bus.o_a_ready = grant_a;
   assign bus.o_b_ready = grant_b;
   assign bus.o_we      = we_q;
   assign bus.o_addr_wr = addr_q;
   assign bus.o_dat_wr  = dat_q;

endmodule
